islip_sched: RTL and testbench

ISLIP_SCHED -- requirements
Module: islip_sched

---
 rtl/sched_pkg.sv | 13 +
 rtl/rr_pick.sv | 27 ++
 rtl/islip_sched.sv | 137 +++++++++++++
 tb/tb_islip_sched.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared types for the 4x4 iSLIP scheduler: port count, port index and FSM states.
package sched_pkg;
  localparam int NPORT = 4;

  typedef logic [1:0] port_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACCEPT = 2'd2,
    DONE   = 2'd3
  } sched_state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import sched_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  port_idx_t        ptr,
  output logic [NPORT-1:0] pick,
  output port_idx_t        idx,
  output logic             valid
);
  port_idx_t cand;

  always_comb begin
    pick  = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = ptr;
    for (int k = 0; k < NPORT; k++) begin
      cand = ptr + port_idx_t'(k);
      if (!valid && req[cand]) begin
        valid      = 1'b1;
        idx        = cand;
        pick[cand] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/islip_sched.sv
// 4x4 iSLIP scheduler: IDLE -> (GRANT -> ACCEPT)xN -> DONE -> IDLE.
// ISLIP_MULTI_ITER_EN enables up to ITERS grant/accept iterations; otherwise one iteration.
module islip_sched
  import sched_pkg::*;
#(
  parameter int ITERS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sched_en,
  input  logic [15:0] voq_empty,
  output logic [3:0]  sched_sel_en,
  output logic [7:0]  sched_sel,
  output logic        sched_busy,
  output logic        sched_done
);
`ifdef ISLIP_MULTI_ITER_EN
  localparam logic [2:0] MAX_ITERS = 3'(ITERS);
`else
  // ITERS is accepted for interface compatibility but has no effect here.
  localparam logic [2:0] MAX_ITERS = (ITERS > 0) ? 3'd1 : 3'd1;
`endif

  sched_state_t state_reg, state_next;

  logic [NPORT-1:0][NPORT-1:0] req_reg;  // [ingress][egress]
  logic [NPORT-1:0]            in_matched_reg, out_matched_reg;
  port_idx_t [NPORT-1:0]       match_reg;
  port_idx_t [NPORT-1:0]       grant_ptr_reg, accept_ptr_reg;
  logic [NPORT-1:0]            grant_valid_reg;
  port_idx_t [NPORT-1:0]       grant_idx_reg;
  logic [2:0]                  iter_reg;
  logic [7:0]                  sel_hold_reg;

  logic [NPORT-1:0]            grant_valid;
  port_idx_t [NPORT-1:0]       grant_idx;
  logic [NPORT-1:0][NPORT-1:0] grant_pick_unused;
  logic [NPORT-1:0]            accept_valid;
  port_idx_t [NPORT-1:0]       accept_idx;
  logic [NPORT-1:0][NPORT-1:0] accept_pick;  // [ingress] one-hot over egress
  logic [NPORT-1:0]            out_new;

  // Per port gi: grant arbiter for egress gi, accept arbiter for ingress gi.
  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    logic [NPORT-1:0] grant_req, accept_req;
    for (genvar gk = 0; gk < NPORT; gk++) begin : g_bit
      assign grant_req[gk]  = req_reg[gk][gi] & ~in_matched_reg[gk] & ~out_matched_reg[gi];
      assign accept_req[gk] = grant_valid_reg[gk] & (grant_idx_reg[gk] == port_idx_t'(gi))
                              & ~in_matched_reg[gi];
    end
    rr_pick u_grant (
      .req  (grant_req),
      .ptr  (grant_ptr_reg[gi]),
      .pick (grant_pick_unused[gi]),
      .idx  (grant_idx[gi]),
      .valid(grant_valid[gi])
    );
    rr_pick u_accept (
      .req  (accept_req),
      .ptr  (accept_ptr_reg[gi]),
      .pick (accept_pick[gi]),
      .idx  (accept_idx[gi]),
      .valid(accept_valid[gi])
    );
  end

  always_comb begin
    out_new = '0;
    for (int i = 0; i < NPORT; i++) out_new = out_new | accept_pick[i];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sched_en) state_next = GRANT;
      GRANT:   state_next = ACCEPT;
      ACCEPT:  if (!(|accept_valid) || ((iter_reg + 3'd1) >= MAX_ITERS)) state_next = DONE;
               else state_next = GRANT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      req_reg         <= '0;
      in_matched_reg  <= '0;
      out_matched_reg <= '0;
      match_reg       <= '0;
      grant_ptr_reg   <= '0;
      accept_ptr_reg  <= '0;
      grant_valid_reg <= '0;
      grant_idx_reg   <= '0;
      iter_reg        <= '0;
      sel_hold_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (sched_en) begin
          for (int i = 0; i < NPORT; i++)
            for (int j = 0; j < NPORT; j++)
              req_reg[i][j] <= ~voq_empty[NPORT*i+j];
          in_matched_reg  <= '0;
          out_matched_reg <= '0;
          match_reg       <= '0;
          iter_reg        <= '0;
        end
        GRANT: begin
          grant_valid_reg <= grant_valid;
          grant_idx_reg   <= grant_idx;
        end
        ACCEPT: begin
          in_matched_reg  <= in_matched_reg | accept_valid;
          out_matched_reg <= out_matched_reg | out_new;
          iter_reg        <= iter_reg + 3'd1;
          // Pointers move only on first-iteration accepts to keep iSLIP's desynchronisation.
          for (int i = 0; i < NPORT; i++) begin
            if (accept_valid[i]) begin
              match_reg[i] <= accept_idx[i];
              if (iter_reg == 3'd0) accept_ptr_reg[i] <= accept_idx[i] + port_idx_t'(1);
            end
          end
          for (int j = 0; j < NPORT; j++)
            if (out_new[j] && iter_reg == 3'd0) grant_ptr_reg[j] <= grant_idx_reg[j] + port_idx_t'(1);
        end
        DONE: sel_hold_reg <= match_reg;
        default: ;
      endcase
    end
  end

  assign sched_busy   = (state_reg != IDLE);
  assign sched_done   = (state_reg == DONE);
  assign sched_sel_en = sched_done ? in_matched_reg : '0;
  assign sched_sel    = sched_done ? match_reg : sel_hold_reg;
endmodule

// File: tb/tb_islip_sched.sv
// Directed table-driven bench for islip_sched plus hand sequences for busy-ignore and mid-round reset.
module tb_islip_sched;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sched_en = 1'b0;
  logic [15:0] voq_empty = 16'hFFFF;
  logic [3:0]  sched_sel_en;
  logic [7:0]  sched_sel;
  logic        sched_busy, sched_done;

  int checks = 0;
  int errors = 0;

  islip_sched #(.ITERS(2)) dut (
    .clk(clk), .reset(reset), .sched_en(sched_en), .voq_empty(voq_empty),
    .sched_sel_en(sched_sel_en), .sched_sel(sched_sel),
    .sched_busy(sched_busy), .sched_done(sched_done)
  );

  always #5 clk = ~clk;

`ifdef ISLIP_MULTI_ITER_EN
  localparam int         LATF = 5;
  localparam logic [3:0] EN1 = 4'b0011;
  localparam logic [7:0] SEL1 = 8'h04;
  localparam logic [3:0] EN2 = 4'b0111;
  localparam logic [7:0] SEL2 = 8'h21;
`else
  localparam int         LATF = 3;
  localparam logic [3:0] EN1 = 4'b0001;
  localparam logic [7:0] SEL1 = 8'h00;
  localparam logic [3:0] EN2 = 4'b0011;
  localparam logic [7:0] SEL2 = 8'h01;
`endif

  typedef struct {
    logic        rst;
    logic [15:0] ve;
    logic [3:0]  en;
    logic [7:0]  sel;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Start a round, scramble voq_empty after the latch edge, wait (bounded) for sched_done.
  task automatic run_round(input logic [15:0] ve, output logic [3:0] en,
                           output logic [7:0] sel, output int lat);
    @(negedge clk);
    voq_empty = ve;
    sched_en  = 1'b1;
    @(posedge clk);
    #1;
    sched_en  = 1'b0;
    voq_empty = ~ve;
    lat = 1;
    while (!sched_done && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    en  = sched_sel_en;
    sel = sched_sel;
  endtask

  initial begin
    logic [3:0] en_got;
    logic [7:0] sel_got;
    int         lat_got;
    int         done_cnt;

    vecs[0] = '{1'b1, 16'hFFFF, 4'b0000, 8'h00, 3};
    vecs[1] = '{1'b0, 16'h0000, EN1,     SEL1,  LATF};
    vecs[2] = '{1'b0, 16'h0000, EN2,     SEL2,  LATF};
    vecs[3] = '{1'b1, 16'hF7FF, 4'b0100, 8'h30, LATF};
    vecs[4] = '{1'b1, 16'h7BDE, 4'b1111, 8'hE4, LATF};
    vecs[5] = '{1'b1, 16'hAFBB, 4'b1001, 8'h02, LATF};
    vecs[6] = '{1'b0, 16'hAFBB, 4'b1010, 8'h08, LATF};
    vecs[7] = '{1'b0, 16'hAFBB, 4'b1000, 8'h80, LATF};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(sched_busy), 0);
    check("rst_done", 32'(sched_done), 0);
    check("rst_sel_en", 32'(sched_sel_en), 0);
    check("rst_sel", 32'(sched_sel), 0);
    @(negedge clk);
    reset = 1'b0;

    // sched_en held through GRANT/ACCEPT must not start extra rounds.
    do_reset();
    @(negedge clk);
    voq_empty = 16'h0000;
    sched_en  = 1'b1;
    done_cnt  = 0;
    en_got    = '0;
    sel_got   = '0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 2) sched_en = 1'b0;
      if (sched_done) begin
        done_cnt++;
        en_got  = sched_sel_en;
        sel_got = sched_sel;
      end
    end
    check("busy_ign_done_cnt", 32'(done_cnt), 1);
    check("busy_ign_en", 32'(en_got), 32'(EN1));
    check("busy_ign_sel", 32'(sel_got), 32'(SEL1));

    for (int r = 0; r < 8; r++) begin
      if (vecs[r].rst) do_reset();
      run_round(vecs[r].ve, en_got, sel_got, lat_got);
      check($sformatf("row%0d_en", r), 32'(en_got), 32'(vecs[r].en));
      check($sformatf("row%0d_sel", r), 32'(sel_got), 32'(vecs[r].sel));
      check($sformatf("row%0d_lat", r), 32'(lat_got), 32'(vecs[r].lat));
      @(posedge clk);
      #1;
      check($sformatf("row%0d_idle_busy", r), 32'(sched_busy), 0);
      check($sformatf("row%0d_idle_en", r), 32'(sched_sel_en), 0);
      check($sformatf("row%0d_hold_sel", r), 32'(sched_sel), 32'(vecs[r].sel));
      $display("row %0d voq_empty=%h en=%b sel=%h lat=%0d", r, vecs[r].ve, en_got, sel_got, lat_got);
    end

    // Reset during ACCEPT, with sched_en asserted alongside it.
    @(negedge clk);
    voq_empty = 16'h0000;
    sched_en  = 1'b1;
    @(posedge clk);
    #1;
    sched_en = 1'b0;
    @(posedge clk);
    #1;
    check("mid_busy", 32'(sched_busy), 1);
    @(negedge clk);
    reset    = 1'b1;
    sched_en = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_busy", 32'(sched_busy), 0);
    check("mid_rst_done", 32'(sched_done), 0);
    check("mid_rst_en", 32'(sched_sel_en), 0);
    check("mid_rst_sel", 32'(sched_sel), 0);
    @(negedge clk);
    reset    = 1'b0;
    sched_en = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_en_ignored", 32'(sched_busy), 0);
    run_round(16'h0000, en_got, sel_got, lat_got);
    check("post_rst_en", 32'(en_got), 32'(EN1));
    check("post_rst_sel", 32'(sel_got), 32'(SEL1));
    check("post_rst_lat", 32'(lat_got), 32'(LATF));
    $display("post-reset round en=%b sel=%h lat=%0d", en_got, sel_got, lat_got);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
